vga_tile_renderer: RTL and testbench

//  Parametrised VGA timing generator plus tile-map pixel renderer for the game display.

---
 rtl/vga_tile_pkg.sv | 34 +++
 rtl/vga_timing_gen.sv | 100 ++++++++++
 rtl/vga_tile_renderer.sv | 166 ++++++++++++++++
 tb/tb_vga_tile_renderer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_tile_pkg.sv
// Shared tile class codes, default colours and 640x480@60 timing defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_tile_pkg;

    // Class of the tile currently under the raster, as returned by game logic
    typedef enum logic [1:0] {
        TILE_NONE = 2'b00,
        TILE_HEAD = 2'b01,
        TILE_BODY = 2'b10,
        TILE_WALL = 2'b11
    } tile_class_e;

    // Raster coordinate width (covers up to 1023 columns/lines)
    localparam int POS_W = 10;

    // 640x480@60 timing
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Default palette
    localparam logic [2:0] HEAD_COLOR_DEF  = 3'b010;
    localparam logic [2:0] BODY_COLOR_DEF  = 3'b011;
    localparam logic [2:0] APPLE_COLOR_DEF = 3'b001;
    localparam logic [2:0] BG_COLOR_DEF    = 3'b111;
    localparam logic [2:0] WALL_COLOR_DEF  = 3'b111;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-clock divider, raster x/y counters, tile coordinates and raw sync/active flags.
// Latency: coordinates registered; raw flags are combinational from the presented coordinate.
// Backpressure: none; free-running raster.
module vga_timing_gen
    import vga_tile_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter int CLK_DIV   = 2,
    parameter int TILE_LOG2 = 4,
    parameter int TX_W      = 6,
    parameter int TY_W      = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             pix_ce_o,
    output logic             frame_start_o,
    output logic [POS_W-1:0] x_o,
    output logic [POS_W-1:0] y_o,
    output logic [TX_W-1:0]  tile_x_o,
    output logic [TY_W-1:0]  tile_y_o,
    output logic             hs_act_o,
    output logic             vs_act_o,
    output logic             de_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] H_ACT    = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] V_ACT    = POS_W'(V_ACTIVE);
    localparam logic [POS_W-1:0] H_SYNC_S = POS_W'(H_ACTIVE + H_FP);
    localparam logic [POS_W-1:0] H_SYNC_E = POS_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [POS_W-1:0] V_SYNC_S = POS_W'(V_ACTIVE + V_FP);
    localparam logic [POS_W-1:0] V_SYNC_E = POS_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_ce_q, pix_ce_d;
    logic [POS_W-1:0] x_q, x_d, y_q, y_d;
    logic [TX_W-1:0]  tile_x_q, tile_x_d;
    logic [TY_W-1:0]  tile_y_q, tile_y_d;

    // Next-state: divider phase, strobe for the coming clock, raster advance on the strobe
    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        pix_ce_d = (div_d == DIV_LAST);
        x_d      = x_q;
        y_d      = y_q;
        if (pix_ce_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        tile_x_d = TX_W'(x_d >> TILE_LOG2);
        tile_y_d = TY_W'(y_d >> TILE_LOG2);
    end

    // State registers; reset restarts the raster at (0,0) with the strobe low
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q    <= '0;
            pix_ce_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            tile_x_q <= '0;
            tile_y_q <= '0;
        end else begin
            div_q    <= div_d;
            pix_ce_q <= pix_ce_d;
            x_q      <= x_d;
            y_q      <= y_d;
            tile_x_q <= tile_x_d;
            tile_y_q <= tile_y_d;
        end
    end

    assign pix_ce_o      = pix_ce_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign tile_x_o      = tile_x_q;
    assign tile_y_o      = tile_y_q;
    assign frame_start_o = pix_ce_q && (x_q == '0) && (y_q == '0);
    assign hs_act_o      = (x_q >= H_SYNC_S) && (x_q <= H_SYNC_E);
    assign vs_act_o      = (y_q >= V_SYNC_S) && (y_q <= V_SYNC_E);
    assign de_o          = (x_q < H_ACT) && (y_q < V_ACT);

endmodule

// File: rtl/vga_tile_renderer.sv
// VGA timing plus tile-map colour pipeline; optional dotted tile grid via VGA_TILE_GRID_EN.
// Latency: color_out/de/hsync/vsync lag x_pos/y_pos by exactly 2 pixel ticks.
// Backpressure: none; game logic must answer a presented coordinate before the next pix_ce.
module vga_tile_renderer
    import vga_tile_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter logic SYNC_POL = 1'b0,
    parameter int CLK_DIV   = 2,
    parameter int TILE_LOG2 = 4,
    parameter int TX_W      = 6,
    parameter int TY_W      = 5,
    parameter int COLOR_W   = 3,
    parameter logic [COLOR_W-1:0] HEAD_COLOR  = COLOR_W'(HEAD_COLOR_DEF),
    parameter logic [COLOR_W-1:0] BODY_COLOR  = COLOR_W'(BODY_COLOR_DEF),
    parameter logic [COLOR_W-1:0] APPLE_COLOR = COLOR_W'(APPLE_COLOR_DEF),
    parameter logic [COLOR_W-1:0] BG_COLOR    = COLOR_W'(BG_COLOR_DEF),
    parameter logic [COLOR_W-1:0] WALL_COLOR  = COLOR_W'(WALL_COLOR_DEF)
) (
    input  logic               CLK_50M,
    input  logic               RSTn,
    input  logic [1:0]         tile_class,
    input  logic [TX_W-1:0]    apple_x,
    input  logic [TY_W-1:0]    apple_y,
    input  logic               ovl_hit,
    input  logic [COLOR_W-1:0] ovl_color,
    output logic [POS_W-1:0]   x_pos,
    output logic [POS_W-1:0]   y_pos,
    output logic [TX_W-1:0]    tile_x,
    output logic [TY_W-1:0]    tile_y,
    output logic               pix_ce,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COLOR_W-1:0] color_out
);

    logic hs_act, vs_act, de_raw;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CLK_DIV  (CLK_DIV),
        .TILE_LOG2(TILE_LOG2),
        .TX_W     (TX_W),
        .TY_W     (TY_W)
    ) u_timing (
        .clk_i        (CLK_50M),
        .rst_ni       (RSTn),
        .pix_ce_o     (pix_ce),
        .frame_start_o(frame_start),
        .x_o          (x_pos),
        .y_o          (y_pos),
        .tile_x_o     (tile_x),
        .tile_y_o     (tile_y),
        .hs_act_o     (hs_act),
        .vs_act_o     (vs_act),
        .de_o         (de_raw)
    );

    // Stage 1: lookup results plus the raster flags of the same pixel
    tile_class_e        s1_class_q;
    logic               s1_apple_q;
    logic               s1_ovl_q;
    logic [COLOR_W-1:0] s1_ovl_col_q;
    logic               s1_de_q, s1_hs_q, s1_vs_q;

    // Stage 2: resolved colour and aligned syncs
    logic [COLOR_W-1:0] color_q, color_d;
    logic               de_q, hsync_q, vsync_q;
    logic               grid_dot;

`ifdef VGA_TILE_GRID_EN
    logic [TILE_LOG2-1:0] s1_off_x_q, s1_off_y_q;

    // Tile-local offsets follow their pixel into stage 1 for the grid-dot decision
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            s1_off_x_q <= '0;
            s1_off_y_q <= '0;
        end else if (pix_ce) begin
            s1_off_x_q <= x_pos[TILE_LOG2-1:0];
            s1_off_y_q <= y_pos[TILE_LOG2-1:0];
        end
    end
`endif

    // Sample game-logic answers for the presented coordinate; apple match uses the live apple position
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            s1_class_q   <= TILE_NONE;
            s1_apple_q   <= 1'b0;
            s1_ovl_q     <= 1'b0;
            s1_ovl_col_q <= '0;
            s1_de_q      <= 1'b0;
            s1_hs_q      <= 1'b0;
            s1_vs_q      <= 1'b0;
        end else if (pix_ce) begin
            s1_class_q   <= tile_class_e'(tile_class);
            s1_apple_q   <= (tile_x == apple_x) && (tile_y == apple_y);
            s1_ovl_q     <= ovl_hit;
            s1_ovl_col_q <= ovl_color;
            s1_de_q      <= de_raw;
            s1_hs_q      <= hs_act;
            s1_vs_q      <= vs_act;
        end
    end

    // Colour priority: overlay, apple, snake/wall class, background; black outside the active area
    always_comb begin
        grid_dot = 1'b0;
`ifdef VGA_TILE_GRID_EN
        grid_dot = (s1_off_x_q == '0) && (s1_off_y_q == '0);
`endif
        color_d = '0;
        if (s1_de_q) begin
            if (s1_ovl_q) begin
                color_d = s1_ovl_col_q;
            end else if (s1_apple_q) begin
                color_d = grid_dot ? '0 : APPLE_COLOR;
            end else begin
                case (s1_class_q)
                    TILE_HEAD: color_d = grid_dot ? '0 : HEAD_COLOR;
                    TILE_BODY: color_d = grid_dot ? '0 : BODY_COLOR;
                    TILE_WALL: color_d = WALL_COLOR;
                    default:   color_d = BG_COLOR;
                endcase
            end
        end
    end

    // Output register: colour, de and syncs leave together; syncs idle at the inactive level
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            color_q <= '0;
            de_q    <= 1'b0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
        end else if (pix_ce) begin
            color_q <= color_d;
            de_q    <= s1_de_q;
            hsync_q <= s1_hs_q ? SYNC_POL : ~SYNC_POL;
            vsync_q <= s1_vs_q ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign color_out = color_q;
    assign de        = de_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Self-checking bench for vga_tile_renderer on a reduced raster (80x55, CLK_DIV=2).
// Latency: expects outputs 2 pixel ticks behind the presented coordinate.
// Backpressure: n/a.
module tb_vga_tile_renderer;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 48, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int CD = 2;
    localparam int TL = 4;
    localparam int TXW = 6;
    localparam int TYW = 5;
    localparam logic SPOL = 1'b0;
    localparam logic [2:0] C_HEAD = 3'b010, C_BODY = 3'b011, C_APPLE = 3'b001;
    localparam logic [2:0] C_BG = 3'b111, C_WALL = 3'b111;
`ifdef VGA_TILE_GRID_EN
    localparam logic [2:0] G_HEAD = 3'b000, G_APPLE = 3'b000;
`else
    localparam logic [2:0] G_HEAD = C_HEAD, G_APPLE = C_APPLE;
`endif
    localparam int NV = 13;
    localparam int RAND_TICKS = 2 * FRAME + FRAME / 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  tile_class = 2'b00;
    logic [5:0]  apple_x = 6'd4;
    logic [4:0]  apple_y = 5'd3;
    logic        ovl_hit = 1'b0;
    logic [2:0]  ovl_color = 3'b000;
    logic [9:0]  x_pos, y_pos;
    logic [5:0]  tile_x;
    logic [4:0]  tile_y;
    logic        pix_ce, frame_start, hsync, vsync, de;
    logic [2:0]  color_out;

    vga_tile_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(SPOL), .CLK_DIV(CD), .TILE_LOG2(TL), .TX_W(TXW), .TY_W(TYW), .COLOR_W(3)
    ) dut (
        .CLK_50M    (clk),
        .RSTn       (rstn),
        .tile_class (tile_class),
        .apple_x    (apple_x),
        .apple_y    (apple_y),
        .ovl_hit    (ovl_hit),
        .ovl_color  (ovl_color),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .tile_x     (tile_x),
        .tile_y     (tile_y),
        .pix_ce     (pix_ce),
        .frame_start(frame_start),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .color_out  (color_out)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [2:0] col;
        logic       de;
        logic       hs;
        logic       vs;
    } px_t;

    typedef struct {
        int         x;
        int         y;
        logic [1:0] cls;
        int         ax;
        int         ay;
        bit         oh;
        logic [2:0] oc;
        logic [2:0] ecol;
        bit         ede;
    } vec_t;

    px_t  exp_q[$];
    int   n_pix;
    int   checks = 0;
    int   failures = 0;
    vec_t vt[NV];
    logic [1:0] tmap[8][4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int mx();
        return n_pix % HT;
    endfunction

    function automatic int my();
        return (n_pix / HT) % VT;
    endfunction

    // Reference: what the screen should show for raster pixel (x,y) given the lookup answers
    function automatic px_t model_px(input int x, input int y, input logic [1:0] cls,
                                     input int ax, input int ay, input bit oh, input logic [2:0] oc);
        px_t p;
        bit  apple;
        bit  corner;
        p.de  = (x < HA) && (y < VA);
        p.hs  = (x >= HA + HF && x < HA + HF + HS) ? SPOL : ~SPOL;
        p.vs  = (y >= VA + VF && y < VA + VF + VS) ? SPOL : ~SPOL;
        apple = (((x >> TL) % (1 << TXW)) == ax) && (((y >> TL) % (1 << TYW)) == ay);
        corner = 1'b0;
`ifdef VGA_TILE_GRID_EN
        corner = ((x % (1 << TL)) == 0) && ((y % (1 << TL)) == 0);
`endif
        p.col = 3'b000;
        if (!p.de)         p.col = 3'b000;
        else if (oh)       p.col = oc;
        else if (apple)    p.col = corner ? 3'b000 : C_APPLE;
        else if (cls == 2'b01) p.col = corner ? 3'b000 : C_HEAD;
        else if (cls == 2'b10) p.col = corner ? 3'b000 : C_BODY;
        else if (cls == 2'b11) p.col = C_WALL;
        else               p.col = C_BG;
        return p;
    endfunction

    task automatic reset_model();
        px_t idle;
        idle = '{col: 3'b000, de: 1'b0, hs: ~SPOL, vs: ~SPOL};
        exp_q.delete();
        exp_q.push_back(idle);
        exp_q.push_back(idle);
        n_pix = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {x_pos, y_pos, tile_x, tile_y, pix_ce, frame_start, de, color_out}, 64'd0);
        check({name, "_sync"}, {hsync, vsync}, {~SPOL, ~SPOL});
    endtask

    // Advance to the next negedge with pix_ce high; returns clocks waited
    task automatic wait_tick(output int gap);
        gap = 0;
        for (int i = 0; i < 8 * CD; i++) begin
            @(negedge clk);
            gap++;
            if (pix_ce === 1'b1) return;
        end
        failures++;
        checks++;
        $display("FAIL tick_timeout actual=no_pix_ce required=pix_ce_within_%0d_clocks", 8 * CD);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // At a tick: check coordinates and the 2-tick-old pixel, then answer the lookup
    task automatic step(input logic [1:0] cls, input int ax, input int ay,
                        input bit oh, input logic [2:0] oc);
        int  x;
        int  y;
        px_t got;
        x = mx();
        y = my();
        check("coord", {x_pos, y_pos, tile_x, tile_y},
              {10'(x), 10'(y), 6'(x >> TL), 5'(y >> TL)});
        check("frame_start", frame_start, (x == 0 && y == 0));
        got = '{col: color_out, de: de, hs: hsync, vs: vsync};
        check("pixel_out", got, exp_q.pop_front());
        tile_class = cls;
        apple_x    = 6'(ax);
        apple_y    = 5'(ay);
        ovl_hit    = oh;
        ovl_color  = oc;
        exp_q.push_back(model_px(x, y, cls, ax, ay, oh, oc));
        n_pix++;
    endtask

    task automatic tick_default();
        int g;
        wait_tick(g);
        step(2'b00, 4, 3, 1'b0, 3'b000);
    endtask

    initial begin
        int pend[$];
        int found;
        int g;
        int hs_start, hs_period, hs_width, lines;
        int vs_start, vs_width, frame_lines, lines_at_vs;
        bit prev_hs, prev_vs;

        //        x   y  cls   ax ay oh  oc      exp col  de
        vt[0]  = '{48,  0, 2'b11, 4, 3, 0, 3'b000, 3'b111, 1};
        vt[1]  = '{ 5, 10, 2'b11, 4, 3, 0, 3'b000, 3'b111, 1};
        vt[2]  = '{ 6, 10, 2'b00, 4, 3, 0, 3'b000, 3'b111, 1};
        vt[3]  = '{16, 16, 2'b01, 4, 3, 1, 3'b101, 3'b101, 1};
        vt[4]  = '{48, 16, 2'b00, 3, 1, 0, 3'b000, G_APPLE, 1};
        vt[5]  = '{20, 20, 2'b10, 4, 3, 0, 3'b000, 3'b011, 1};
        vt[6]  = '{32, 32, 2'b01, 4, 3, 0, 3'b000, G_HEAD, 1};
        vt[7]  = '{33, 32, 2'b01, 4, 3, 0, 3'b000, 3'b010, 1};
        vt[8]  = '{37, 40, 2'b01, 4, 3, 0, 3'b000, 3'b010, 1};
        vt[9]  = '{40, 41, 2'b10, 2, 2, 0, 3'b000, 3'b001, 1};
        vt[10] = '{41, 41, 2'b10, 2, 2, 1, 3'b100, 3'b100, 1};
        vt[11] = '{70, 45, 2'b00, 4, 2, 1, 3'b110, 3'b000, 0};
        vt[12] = '{10, 50, 2'b11, 4, 3, 0, 3'b000, 3'b000, 0};

        // Power-on reset
        #25;
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        reset_model();

        // Directed vectors over one frame, pixels answered as the raster reaches them
        found = 0;
        pend.delete();
        pend.push_back(-1);
        pend.push_back(-1);
        for (int t = 0; t < FRAME + 2; t++) begin
            int idx;
            int p;
            idx = -1;
            wait_tick(g);
            p = pend.pop_front();
            if (p >= 0) begin
                check($sformatf("vec%0d_color", p), color_out, vt[p].ecol);
                check($sformatf("vec%0d_de", p), de, vt[p].ede);
                found++;
            end
            for (int k = 0; k < NV; k++)
                if (vt[k].x == mx() && vt[k].y == my()) idx = k;
            if (idx >= 0)
                step(vt[idx].cls, vt[idx].ax, vt[idx].ay, vt[idx].oh, vt[idx].oc);
            else
                step(2'b00, 4, 3, 1'b0, 3'b000);
            pend.push_back(idx);
        end
        check("vec_count", found, NV);

        // Frame wrap: last pixel of the frame, then (0,0) with a single-clock frame_start
        for (int i = 0; i < FRAME && !(mx() == HT - 1 && my() == VT - 1); i++)
            tick_default();
        tick_default();
        wait_tick(g);
        check("wrap_xy", {x_pos, y_pos}, 20'd0);
        check("wrap_frame_start", frame_start, 1'b1);
        check("wrap_de", de, 1'b0);
        step(2'b00, 4, 3, 1'b0, 3'b000);
        @(negedge clk);
        check("frame_start_one_tick", {pix_ce, frame_start}, 2'b00);

        // Randomised tile map, overlay and apple moves, plus sync period measurement
        for (int tx = 0; tx < 8; tx++)
            for (int ty = 0; ty < 4; ty++)
                tmap[tx][ty] = 2'($urandom_range(0, 3));
        hs_start = -1; hs_period = -1; hs_width = -1; lines = 0;
        vs_start = -1; vs_width = -1; frame_lines = -1; lines_at_vs = 0;
        prev_hs = 1'b1; prev_vs = 1'b1;
        begin
            int ax;
            int ay;
            ax = 4;
            ay = 3;
            for (int i = 0; i < RAND_TICKS && failures < 100; i++) begin
                bit hs_a;
                bit vs_a;
                wait_tick(g);
                if (i > 0) check("pix_ce_gap", g, CD);
                if (i % 397 == 0) begin
                    ax = $urandom_range(0, 4);
                    ay = $urandom_range(0, 3);
                end
                step(tmap[mx() >> TL][my() >> TL], ax, ay,
                     ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)));
                hs_a = (hsync == SPOL);
                vs_a = (vsync == SPOL);
                if (hs_a && !prev_hs) begin
                    if (hs_start >= 0) hs_period = i - hs_start;
                    hs_start = i;
                    lines++;
                end
                if (!hs_a && prev_hs && hs_start >= 0) hs_width = i - hs_start;
                if (vs_a && !prev_vs) begin
                    if (vs_start >= 0) frame_lines = lines - lines_at_vs;
                    vs_start = i;
                    lines_at_vs = lines;
                end
                if (!vs_a && prev_vs && vs_start >= 0) vs_width = i - vs_start;
                prev_hs = hs_a;
                prev_vs = vs_a;
            end
        end
        check("hsync_period_ticks", hs_period, HT);
        check("hsync_width_ticks", hs_width, HS);
        check("vsync_width_ticks", vs_width, VS * HT);
        check("lines_per_frame", frame_lines, VT);

        // Asynchronous reset mid-frame, then refill of the pipe from (0,0)
        for (int i = 0; i < FRAME && !(mx() == 30 && my() == 20); i++)
            tick_default();
        tick_default();
        #3;
        rstn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (3) @(negedge clk);
        check_reset_outputs("mid_reset_hold");
        rstn = 1'b1;
        reset_model();
        wait_tick(g);
        check("rst_first_xy", {x_pos, y_pos}, 20'd0);
        check("rst_first_frame_start", frame_start, 1'b1);
        check("rst_de_tick0", de, 1'b0);
        step(2'b00, 4, 3, 1'b0, 3'b000);
        wait_tick(g);
        check("rst_de_tick1", de, 1'b0);
        step(2'b00, 4, 3, 1'b0, 3'b000);
        wait_tick(g);
        check("rst_de_tick2", {de, color_out}, {1'b1, C_BG});
        step(2'b00, 4, 3, 1'b0, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
